// File: rtl/ms_sched_pkg.sv
// Shared types for the MASTER_START burst sequencer: descriptor layout and FSM states.
// The descriptor packs every MEM_* field that is loaded into the synchronizer in one burst.
package ms_sched_pkg;

    localparam int DESC_W = 338;

    typedef struct packed {
        logic [47:0] freq;
        logic [47:0] freq_step;
        logic [31:0] freq_rate;
        logic [63:0] time_start;
        logic [15:0] n_impuls;
        logic [1:0]  type_impulse;
        logic [31:0] ti;
        logic [31:0] tp;
        logic [31:0] tblank1;
        logic [31:0] tblank2;
    } desc_t;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        WRITE,
        ARMED,
        RUN
    } state_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/desc_fifo.sv
// Descriptor queue: synchronous FIFO holding whole burst descriptors.
// Latency: push visible at the head the cycle after it is written; head read is combinational.
// Backpressure: pushes while full are dropped; flush empties it and discards a same-cycle push.
module desc_fifo
    import ms_sched_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     push_vld,
    input  desc_t                    push_dat,
    input  logic                     pop,
    output desc_t                    head_dat,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    desc_t         mem [DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic          wr_en;
    logic          rd_en;

    // Pointers carry one extra bit so full and empty are distinguishable.
    assign level    = wr_ptr - rd_ptr;
    assign full     = (level == (AW+1)'(DEPTH));
    assign empty    = (level == '0);
    assign wr_en    = push_vld && !full && !flush;
    assign rd_en    = pop && !empty && !flush;
    assign head_dat = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr[AW-1:0]] <= push_dat;
    end

endmodule

// File: rtl/burst_queue_scheduler.sv
// Queues burst descriptors and loads them one at a time into MASTER_START via MEM_* and WR_DATA.
// Latency: PUSH into an empty idle queue raises WR_DATA 3 cycles later (push, pop, check).
// Backpressure: FULL rejects pushes; a new burst is only loaded once the previous one has ended.
module burst_queue_scheduler
    import ms_sched_pkg::*;
#(
    parameter int          DEPTH       = 4,
    parameter int          GUARD       = 64,
    parameter int          WR_LEN      = 4,
    parameter logic [31:0] ARM_TIMEOUT = 32'h00FFFFFF,
    parameter int          IDLE_CYC    = 8
) (
    input  logic                     CLK,
    input  logic                     RESET_n,
    input  logic                     PUSH,
    input  logic [47:0]              IN_FREQ,
    input  logic [47:0]              IN_FREQ_STEP,
    input  logic [31:0]              IN_FREQ_RATE,
    input  logic [63:0]              IN_TIME_START,
    input  logic [15:0]              IN_N_impuls,
    input  logic [1:0]               IN_TYPE_impulse,
    input  logic [31:0]              IN_Ti,
    input  logic [31:0]              IN_Tp,
    input  logic [31:0]              IN_Tblank1,
    input  logic [31:0]              IN_Tblank2,
    output logic                     FULL,
    output logic                     EMPTY,
    output logic [$clog2(DEPTH):0]   LEVEL,
    input  logic                     FLUSH,
    input  logic [63:0]              SYS_TIME_NOW,
    input  logic                     En_Iz,
    input  logic                     En_Pr,
    output logic [47:0]              MEM_DDS_freq,
    output logic [47:0]              MEM_DDS_freq_step,
    output logic [31:0]              MEM_DDS_freq_rate,
    output logic [63:0]              MEM_TIME_START,
    output logic [15:0]              MEM_N_impuls,
    output logic [1:0]               MEM_TYPE_impulse,
    output logic [31:0]              MEM_Ti,
    output logic [31:0]              MEM_Tp,
    output logic [31:0]              MEM_Tblank1,
    output logic [31:0]              MEM_Tblank2,
    output logic                     WR_DATA,
    output logic                     BUSY,
    output logic                     LATE_DROP,
    output logic                     TIMEOUT_ERR,
    output logic [15:0]              DROP_CNT
);

    desc_t       in_dat;
    desc_t       head_dat;
    desc_t       mem_q;
    state_t      state;
    logic [31:0] cnt;
    logic        en_now;
    logic        en_q;
    logic        pop;
    logic        late;
    logic        wr_q;
    logic        to_err_q;
    logic [15:0] drop_cnt_q;

    assign in_dat = '{freq:         IN_FREQ,
                      freq_step:    IN_FREQ_STEP,
                      freq_rate:    IN_FREQ_RATE,
                      time_start:   IN_TIME_START,
                      n_impuls:     IN_N_impuls,
                      type_impulse: IN_TYPE_impulse,
                      ti:           IN_Ti,
                      tp:           IN_Tp,
                      tblank1:      IN_Tblank1,
                      tblank2:      IN_Tblank2};

    desc_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk      (CLK),
        .rst_n    (RESET_n),
        .flush    (FLUSH),
        .push_vld (PUSH),
        .push_dat (in_dat),
        .pop      (pop),
        .head_dat (head_dat),
        .full     (FULL),
        .empty    (EMPTY),
        .level    (LEVEL)
    );

    assign en_now = En_Iz | En_Pr;
    assign pop    = (state == IDLE) && !EMPTY && !FLUSH;
    assign late   = (mem_q.time_start <= SYS_TIME_NOW + 64'(GUARD));

    // The late decision is flagged in the CHECK cycle itself, not a cycle after it.
    assign LATE_DROP   = (state == CHECK) && !FLUSH && late;
    assign WR_DATA     = wr_q;
    assign TIMEOUT_ERR = to_err_q;
    assign DROP_CNT    = drop_cnt_q;
    assign BUSY        = (state != IDLE);

    assign MEM_DDS_freq      = mem_q.freq;
    assign MEM_DDS_freq_step = mem_q.freq_step;
    assign MEM_DDS_freq_rate = mem_q.freq_rate;
    assign MEM_TIME_START    = mem_q.time_start;
    assign MEM_N_impuls      = mem_q.n_impuls;
    assign MEM_TYPE_impulse  = mem_q.type_impulse;
    assign MEM_Ti            = mem_q.ti;
    assign MEM_Tp            = mem_q.tp;
    assign MEM_Tblank1       = mem_q.tblank1;
    assign MEM_Tblank2       = mem_q.tblank2;

    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            state      <= IDLE;
            mem_q      <= '0;
            cnt        <= '0;
            en_q       <= 1'b0;
            wr_q       <= 1'b0;
            to_err_q   <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            en_q     <= en_now;
            to_err_q <= 1'b0;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (pop) begin
                        mem_q <= head_dat;
                        state <= CHECK;
                    end
                end
                CHECK: begin
                    cnt <= '0;
                    if (FLUSH) begin
                        state <= IDLE;
                    end else if (late) begin
                        drop_cnt_q <= sat_inc16(drop_cnt_q);
                        state      <= IDLE;
                    end else begin
                        wr_q  <= 1'b1;
                        state <= WRITE;
                    end
                end
                WRITE: begin
                    if (cnt == 32'(WR_LEN - 1)) begin
                        wr_q  <= 1'b0;
                        cnt   <= '0;
                        state <= ARMED;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                ARMED: begin
                    // The timeout only runs once the scheduled start time has passed.
                    if (en_now && !en_q) begin
                        cnt   <= '0;
                        state <= RUN;
                    end else if (SYS_TIME_NOW > mem_q.time_start) begin
                        if (cnt == ARM_TIMEOUT - 32'd1) begin
                            to_err_q   <= 1'b1;
                            drop_cnt_q <= sat_inc16(drop_cnt_q);
                            cnt        <= '0;
                            state      <= IDLE;
                        end else begin
                            cnt <= cnt + 32'd1;
                        end
                    end
                end
                RUN: begin
                    if (en_now) begin
                        cnt <= '0;
                    end else if (cnt == 32'(IDLE_CYC - 1)) begin
                        cnt   <= '0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/burst_queue_scheduler.md
Name: burst_queue_scheduler

Overview:
Sequencer in front of MASTER_START, the 48 MHz synchronizer.
- Accepts pulse-burst descriptors from the control side into a small queue: DDS frequency, step, rate, start time, impulse count/type, Ti/Tp, Tblank1/2.
- Loads them one at a time into MASTER_START by driving its MEM_* bus and pulsing WR_DATA.
- Never overwrites a burst in progress. Drops any descriptor whose start time can no longer be met.

Parameters:
DEPTH, 4, descriptor queue depth (power of 2, 2..16)
GUARD, 64, minimum lead in CLK cycles between load and TIME_START
WR_LEN, 4, WR_DATA pulse width in CLK cycles
ARM_TIMEOUT, 32'h00FFFFFF, cycles in ARMED beyond TIME_START before abort
IDLE_CYC, 8, consecutive cycles with En_Iz=En_Pr=0 that mark burst end

Ports:
CLK  in  1  48 MHz clock
RESET_n  in  1  asynchronous active-low reset
PUSH  in  1  write descriptor from the IN_* fields (ignored when FULL)
IN_FREQ/IN_FREQ_STEP  in  48 each  DDS start frequency / step
IN_FREQ_RATE  in  32  DDS step rate
IN_TIME_START  in  64  absolute start time, system-time units
IN_N_impuls  in  16;  IN_TYPE_impulse  in  2
IN_Ti/IN_Tp/IN_Tblank1/IN_Tblank2  in  32 each
FULL/EMPTY  out  1  queue status
LEVEL  out  $clog2(DEPTH)+1  descriptors held
FLUSH  in  1  discard queue; abort only if not yet WRITE
SYS_TIME_NOW  in  64  current system time (same base as MASTER_START)
En_Iz/En_Pr  in  1  MASTER_START outputs
MEM_DDS_freq..MEM_Tblank2  out  per MASTER_START  registered descriptor fields
WR_DATA  out  1  load strobe to MASTER_START
BUSY  out  1  state != IDLE
LATE_DROP  out  1  one-cycle pulse, descriptor dropped as late
TIMEOUT_ERR  out  1  one-cycle pulse, armed burst never started
DROP_CNT  out  16  late+timeout count, saturating

Behaviour:
- Reset: all outputs 0; queue empty (EMPTY=1); DROP_CNT=0; state IDLE.
- Queue: synchronous FIFO, 338-bit entries.
  - PUSH while FULL: entry ignored, no state change.
  - PUSH with pop in the same cycle: both happen; LEVEL unchanged.
  - Pointers wrap mod DEPTH.
- FSM:
  - IDLE: when !EMPTY, register head into the MEM_* output registers and pop (1 cycle) -> CHECK.
  - CHECK (1 cycle): compare TIME_START against SYS_TIME_NOW+GUARD, 64-bit unsigned, no wrap handling.
    - If TIME_START <= SYS_TIME_NOW+GUARD: LATE_DROP=1, DROP_CNT++ -> IDLE.
    - Else -> WRITE.
  - WRITE: WR_DATA=1 for exactly WR_LEN cycles; MEM_* held stable from CHECK until RUN exits -> ARMED.
  - ARMED: wait for rising edge of En_Iz|En_Pr -> RUN.
    - If SYS_TIME_NOW > TIME_START and ARM_TIMEOUT further cycles elapse without it: TIMEOUT_ERR=1, DROP_CNT++ -> IDLE.
  - RUN: counter of consecutive cycles with En_Iz=En_Pr=0.
    - Reset the counter on any 1.
    - On reaching IDLE_CYC -> IDLE; next descriptor can issue the following cycle.
- MEM_* are not cleared on return to IDLE; they keep the last value.
- FLUSH:
  - Empties the queue immediately.
  - In CHECK: return to IDLE without WR and without LATE_DROP.
  - In WRITE/ARMED/RUN: finish the current burst normally; FLUSH does not shorten the WR pulse.
  - PUSH in the same cycle as FLUSH is discarded.
- LATE_DROP and TIMEOUT_ERR are never asserted in the same cycle. DROP_CNT holds at 16'hFFFF.
- RESET_n low mid-burst: everything returns to reset values asynchronously, including WR_DATA=0.
- Latency: PUSH into empty queue in IDLE -> WR_DATA rises 3 cycles later (push, pop, check).

Decomposition:
- Package ms_sched_pkg:
  - descriptor struct typedef (field widths as in Ports);
  - state enum {IDLE, CHECK, WRITE, ARMED, RUN};
  - DESC_W=338 constant.
- Sub-module desc_fifo (parameter DEPTH, packed struct payload, FULL/EMPTY/LEVEL, flush input).
- FSM and counters live in the top.

Test Plan:
- Reset then one PUSH with TIME_START=64'h12C0, SYS_TIME_NOW=0, N_impuls=2, Ti=Tp=32'h1800 -> WR_DATA high 4 cycles starting 3 cycles after PUSH; MEM_DDS_freq=48'h1000000000 stable until En_Iz/En_Pr are low for 8 cycles.
- Push 3 descriptors while a burst runs (En_Iz driven high 1000 cycles) -> no second WR_DATA until 8 idle cycles after En_Iz falls; LEVEL counts 3->2->1->0 over the issues.
- PUSH with TIME_START=SYS_TIME_NOW+10 -> LATE_DROP pulse 2 cycles later; no WR_DATA; DROP_CNT=1; next queued entry issues.
- PUSH 5 entries with DEPTH=4 -> FULL after 4th; 5th ignored; LEVEL=4 minus pops.
- After WRITE, hold En_Iz=En_Pr=0 past TIME_START+ARM_TIMEOUT (set to 100) -> TIMEOUT_ERR pulse, state IDLE, DROP_CNT increments.
- Assert RESET_n low during WRITE -> WR_DATA, BUSY, MEM_* go 0 immediately; EMPTY=1.
